// File: rtl/and_mon_pkg.sv
// and_mon_pkg: shared types and default sizes for the AND-stage edge window monitor
package and_mon_pkg;
    typedef enum logic {ST_IDLE, ST_COUNT} state_t;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_WINDOW = 16;
    localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/sync_rise_det.sv
// sync_rise_det: synchronises an asynchronous level and flags its rising edges
module sync_rise_det
    import and_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q_sync,
    output logic rise
);
    logic [SYNC_STAGES-1:0] chain;
    logic prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            prev <= chain[SYNC_STAGES-1];
        end
    end
    assign q_sync = chain[SYNC_STAGES-1];
    assign rise = q_sync & ~prev;
endmodule

// File: rtl/and_edge_window_counter.sv
// and_edge_window_counter: counts rising edges of the AND-stage output per fixed window
module and_edge_window_counter
    import and_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WINDOW = DEF_WINDOW,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             level_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             drop_sticky
);
    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    state_t state, state_nxt;
    logic [CNT_W-1:0] acc, acc_nxt, acc_inc;
    logic [WIN_W-1:0] win_cnt, win_nxt;
    logic sat, sat_nxt, sat_inc, rise, unused_level_s, pub, run, take;
    sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst_n(rst_n),
        .d(level_in),
        .q_sync(unused_level_s),
        .rise(rise)
    );
    // A window end publishes the count including this cycle's edge, then restarts.
    always_comb begin
        acc_inc = (rise && !(&acc)) ? acc + 1'b1 : acc;
        sat_inc = sat | (rise & (&acc));
        pub = (state == ST_COUNT) && (win_cnt == WIN_LAST);
        run = (state == ST_COUNT) && en && !pub;
        state_nxt = en ? ST_COUNT : ST_IDLE;
        acc_nxt = run ? acc_inc : '0;
        win_nxt = run ? win_cnt + 1'b1 : '0;
        sat_nxt = run ? sat_inc : 1'b0;
        take = pub && (!out_valid || out_ready);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc <= '0;
            win_cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            state <= ST_IDLE;
            acc <= '0;
            win_cnt <= '0;
            sat <= 1'b0;
        end else begin
            state <= state_nxt;
            acc <= acc_nxt;
            win_cnt <= win_nxt;
            sat <= sat_nxt;
        end
    end
    // A result arriving while the previous one is still held is dropped, not queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_sat <= 1'b0;
            drop_sticky <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
            out_sat <= 1'b0;
            drop_sticky <= 1'b0;
        end else begin
            if (take) begin
                out_valid <= 1'b1;
                out_count <= acc_inc;
                out_sat <= sat_inc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            drop_sticky <= drop_sticky | (pub & out_valid & ~out_ready);
        end
    end
endmodule

// File: tb/tb_and_edge_window_counter.sv
// tb_and_edge_window_counter: scoreboard bench for two counter widths driven by shared stimulus
module tb_and_edge_window_counter;
    localparam int WINDOW = 16;
    localparam int S = 2;
    logic clk = 0, rst_n = 0, en = 0, clr = 0, level_in = 0, out_ready = 0;
    logic v0, s0, d0, v1, s1, d1;
    logic [7:0] c0;
    logic [1:0] c1;
    int vectors = 0, errors = 0;
    always #5 clk = ~clk;

    and_edge_window_counter dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .level_in(level_in),
        .out_valid(v0), .out_ready(out_ready), .out_count(c0), .out_sat(s0), .drop_sticky(d0)
    );
    and_edge_window_counter #(.CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .level_in(level_in),
        .out_valid(v1), .out_ready(out_ready), .out_count(c1), .out_sat(s1), .drop_sticky(d1)
    );

    typedef struct {
        int cnt;
        bit sat;
    } exp_t;
    exp_t q[2][$];
    bit hist[S+1];
    bit counting, held[2], drop[2];
    int cyc, edges;

    task automatic chk(input string name, input int act, input int want);
        vectors++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, want, $time);
        end
    endtask

    // Reference: a level sampled at edge t is seen as an edge at t+S; windows are WINDOW counting cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (hist[i]) hist[i] = 0;
            counting = 0;
            cyc = 0;
            edges = 0;
            for (int k = 0; k < 2; k++) begin
                held[k] = 0;
                drop[k] = 0;
                q[k].delete();
            end
        end else begin
            bit r, pub, xfer;
            int cap;
            exp_t e;
            r = hist[S-1] && !hist[S];
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = level_in;
            if (clr) begin
                counting = 0;
                cyc = 0;
                edges = 0;
                for (int k = 0; k < 2; k++) begin
                    held[k] = 0;
                    drop[k] = 0;
                    q[k].delete();
                end
            end else begin
                pub = 0;
                if (counting) begin
                    edges += int'(r);
                    if (cyc == WINDOW - 1) pub = 1;
                    else cyc++;
                end
                for (int k = 0; k < 2; k++) begin
                    cap = (k == 1) ? 3 : 255;
                    xfer = held[k] && out_ready;
                    if (pub && (!held[k] || xfer)) begin
                        e.cnt = (edges > cap) ? cap : edges;
                        e.sat = edges > cap;
                        q[k].push_back(e);
                        held[k] = 1;
                    end else if (pub) begin
                        drop[k] = 1;
                    end else if (xfer) begin
                        held[k] = 0;
                    end
                end
                if (pub || !en) begin
                    cyc = 0;
                    edges = 0;
                end
                counting = en;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic v, s, d;
            int c;
            v = (k == 1) ? v1 : v0;
            s = (k == 1) ? s1 : s0;
            d = (k == 1) ? d1 : d0;
            c = (k == 1) ? int'(c1) : int'(c0);
            chk($sformatf("out_valid[%0d]", k), int'(v), int'(held[k]));
            chk($sformatf("drop_sticky[%0d]", k), int'(d), int'(drop[k]));
            if (v && q[k].size() > 0) begin
                chk($sformatf("out_count[%0d]", k), c, q[k][0].cnt);
                chk($sformatf("out_sat[%0d]", k), int'(s), int'(q[k][0].sat));
                if (out_ready) void'(q[k].pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int waited;
        rst_n = 0;
        #1;
        chk("reset_count0", int'(c0), 0);
        chk("reset_count1", int'(c1), 0);
        tick(3);
        rst_n = 1;
        tick(2);
        en = 1;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            level_in = 1;
            tick(2);
            level_in = 0;
            tick(2);
        end
        tick(40);
        level_in = 1;
        tick(50);
        level_in = 0;
        tick(20);
        out_ready = 0;
        for (int i = 0; i < 40; i++) begin
            level_in = ($urandom_range(0, 2) == 0) ? ~level_in : level_in;
            tick(1);
        end
        out_ready = 1;
        tick(5);
        clr = 1;
        tick(1);
        clr = 0;
        for (int i = 0; i < 48; i++) begin
            level_in = ~level_in;
            tick(1);
        end
        for (int g = 0; g < 4; g++) begin
            en = 0;
            tick(5);
            en = 1;
            for (int i = 0; i < 20; i++) begin
                level_in = ($urandom_range(0, 1) == 0) ? ~level_in : level_in;
                tick(1);
            end
        end
        for (int i = 0; i < 3000; i++) begin
            en = $urandom_range(0, 19) != 0;
            clr = $urandom_range(0, 199) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            level_in = ($urandom_range(0, 2) == 0) ? ~level_in : level_in;
            tick(1);
        end
        clr = 0;
        en = 1;
        out_ready = 0;
        waited = 0;
        while (!v0 && waited < 100) begin
            level_in = ~level_in;
            tick(1);
            waited++;
        end
        chk("wait_valid_before_reset", int'(v0), 1);
        rst_n = 0;
        #1;
        chk("async_rst_valid0", int'(v0), 0);
        chk("async_rst_count0", int'(c0), 0);
        chk("async_rst_drop0", int'(d0), 0);
        chk("async_rst_valid1", int'(v1), 0);
        chk("async_rst_count1", int'(c1), 0);
        chk("async_rst_drop1", int'(d1), 0);
        tick(2);
        rst_n = 1;
        out_ready = 1;
        for (int i = 0; i < 60; i++) begin
            level_in = ($urandom_range(0, 1) == 0) ? ~level_in : level_in;
            tick(1);
        end
        @(negedge clk);
        #1;
        chk("queue_left0", q[0].size(), int'(held[0]));
        chk("queue_left1", q[1].size(), int'(held[1]));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
